// File: rtl/regwr_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regwr_arb_pkg;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    typedef logic [DATA_W-1:0] reg_data_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set bit of req starting at ptr, wrapping mod N.
module rr_picker #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdxW'((32'(ptr) + k) % N);
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single 4x8 register-file write port, with owner lock and timeout.
// Optional per-requester statistics are enabled by defining REG_WRITE_ARB_STATS_EN.
module reg_write_arbiter
    import regwr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned LOCK_TIMEOUT = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data,
    input  logic [NUM_REQ-1:0]                  req_lock,
    output logic [NUM_REGS-1:0][DATA_W-1:0]     regs_in,
    output logic [NUM_REGS-1:0]                 write_en,
    output logic [$clog2(NUM_REQ)-1:0]          lock_owner,
    output logic                                locked
`ifdef REG_WRITE_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]            grant_cnt,
    output logic [7:0]                          lock_to_cnt
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_t             state_q, state_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]        lock_owner_q, lock_owner_d;
    logic [7:0]             timeout_q, timeout_d;
    logic [NUM_REGS-1:0]    write_en_q, write_en_d;
    reg_data_t [NUM_REGS-1:0] regs_in_q, regs_in_d;

    logic [NUM_REQ-1:0]     req_mask;
    logic [NUM_REQ-1:0]     gnt;
    logic [IdxW-1:0]        gnt_idx;
    logic                   gnt_any;
    logic                   accept;
    logic [ADDR_W-1:0]      acc_addr;

    // While locked only the owner may compete for the port.
    always_comb begin
        req_mask = req_valid;
        if (state_q == ARB_LOCKED) begin
            req_mask = req_valid & (NUM_REQ'(1) << lock_owner_q);
        end
    end

    rr_picker #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_picker (
        .req     (req_mask),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign accept    = gnt_any && !rst;
    assign req_ready = rst ? '0 : gnt;
    assign acc_addr  = req_addr[gnt_idx];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_owner_d = lock_owner_q;
        timeout_d    = timeout_q;
        write_en_d   = '0;
        regs_in_d    = '0;
        if (accept) begin
            rr_ptr_d            = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            write_en_d          = addr_onehot(acc_addr);
            regs_in_d[acc_addr] = req_data[gnt_idx];
            if (req_lock[gnt_idx]) begin
                state_d      = ARB_LOCKED;
                lock_owner_d = gnt_idx;
                timeout_d    = '0;
            end else begin
                state_d = ARB_IDLE;
            end
        end else if (state_q == ARB_LOCKED) begin
            timeout_d = timeout_q + 8'd1;
            if (timeout_d == 8'(LOCK_TIMEOUT)) begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            lock_owner_q <= '0;
            timeout_q    <= '0;
            write_en_q   <= '0;
            regs_in_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            timeout_q    <= timeout_d;
            write_en_q   <= write_en_d;
            regs_in_q    <= regs_in_d;
        end
    end

    // Gating with rst drops a write already staged when reset arrives mid-operation.
    assign write_en   = rst ? '0 : write_en_q;
    assign regs_in    = regs_in_q;
    assign lock_owner = lock_owner_q;
    assign locked     = (state_q == ARB_LOCKED);

`ifdef REG_WRITE_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;
    logic [7:0]               lock_to_cnt_q, lock_to_cnt_d;
    logic                     lock_release;

    assign lock_release = (state_q == ARB_LOCKED) && (state_d == ARB_IDLE) && !accept && !rst;

    always_comb begin
        grant_cnt_d   = grant_cnt_q;
        lock_to_cnt_d = lock_to_cnt_q;
        if (accept && grant_cnt_q[gnt_idx] != 16'hFFFF) begin
            grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 16'd1;
        end
        if (lock_release && lock_to_cnt_q != 8'hFF) begin
            lock_to_cnt_d = lock_to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q   <= '0;
            lock_to_cnt_q <= '0;
        end else begin
            grant_cnt_q   <= grant_cnt_d;
            lock_to_cnt_q <= lock_to_cnt_d;
        end
    end

    assign grant_cnt   = grant_cnt_q;
    assign lock_to_cnt = lock_to_cnt_q;
`endif

    a_write_en_onehot0: assert property (@(posedge clk) $onehot0(write_en));
    a_ready_onehot0:    assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (NUM_REQ=3, LOCK_TIMEOUT=8).
module tb_reg_write_arbiter;

    logic             clk;
    logic             rst;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][1:0]  req_addr;
    logic [2:0][7:0]  req_data;
    logic [2:0]       req_lock;
    logic [3:0][7:0]  regs_in;
    logic [3:0]       write_en;
    logic [1:0]       lock_owner;
    logic             locked;
`ifdef REG_WRITE_ARB_STATS_EN
    logic [2:0][15:0] grant_cnt;
    logic [7:0]       lock_to_cnt;
`endif

    int checks;
    int errors;

    reg_write_arbiter #(
        .NUM_REQ      (3),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .regs_in    (regs_in),
        .write_en   (write_en),
        .lock_owner (lock_owner),
        .locked     (locked)
`ifdef REG_WRITE_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .lock_to_cnt(lock_to_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 3'b111;
        req_lock  = 3'b000;
        req_addr  = '{2'd2, 2'd1, 2'd0};
        req_data  = '{8'h33, 8'h22, 8'h11};
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready cyc %0d: got %b want 000", c, req_ready);
            end
            checks++;
            if (write_en !== 4'b0000) begin
                errors++;
                $display("FAIL reset_write_en cyc %0d: got %b want 0000", c, write_en);
            end
            checks++;
            if (regs_in !== 32'h0) begin
                errors++;
                $display("FAIL reset_regs_in cyc %0d: got %h want 0", c, regs_in);
            end
            checks++;
            if (locked !== 1'b0 || lock_owner !== 2'd0) begin
                errors++;
                $display("FAIL reset_lock cyc %0d: got locked=%b owner=%0d want 0/0",
                         c, locked, lock_owner);
            end
            if (c < 2) @(posedge clk);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [3:0][7:0] exp_regs;
        logic [7:0]      dat [3];
        dat = '{8'h11, 8'h22, 8'h33};
        do_reset();
        req_addr  = '{2'd2, 2'd1, 2'd0};
        req_data  = '{8'h33, 8'h22, 8'h11};
        req_valid = 3'b111;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) req_valid = 3'b000;
            @(negedge clk);
            if (c < 6) begin
                checks++;
                if (req_ready !== 3'(1 << (c % 3))) begin
                    errors++;
                    $display("FAIL rr_ready cyc %0d: got %b want %b", c, req_ready,
                             3'(1 << (c % 3)));
                end
            end
            if (c > 0) begin
                exp_regs               = '0;
                exp_regs[(c - 1) % 3]  = dat[(c - 1) % 3];
                checks++;
                if (write_en !== 4'(1 << ((c - 1) % 3)) || regs_in !== exp_regs) begin
                    errors++;
                    $display("FAIL rr_write cyc %0d: got we=%b regs=%h want we=%b regs=%h",
                             c, write_en, regs_in, 4'(1 << ((c - 1) % 3)), exp_regs);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_addr  = '{2'd2, 2'd1, 2'd0};
        req_data  = '{8'h33, 8'h22, 8'h11};
        req_valid = 3'b010;
        req_lock  = 3'b010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (req_ready !== 3'b010 || locked !== (c > 0)) begin
                    errors++;
                    $display("FAIL lock_owner_only cyc %0d: got ready=%b locked=%b want 010/%0d",
                             c, req_ready, locked, c > 0);
                end
            end
            if (c > 0 && c < 5) begin
                checks++;
                if (write_en !== 4'b0010 || regs_in[1] !== 8'h22) begin
                    errors++;
                    $display("FAIL lock_write cyc %0d: got we=%b lane1=%h want 0010/22",
                             c, write_en, regs_in[1]);
                end
            end
            if (c == 2) begin
                checks++;
                if (lock_owner !== 2'd1) begin
                    errors++;
                    $display("FAIL lock_owner_id: got %0d want 1", lock_owner);
                end
            end
            if (c == 4) begin
                checks++;
                if (locked !== 1'b0 || req_ready !== 3'b100) begin
                    errors++;
                    $display("FAIL lock_release_next: got locked=%b ready=%b want 0/100",
                             locked, req_ready);
                end
            end
            if (c == 5) begin
                checks++;
                if (write_en !== 4'b0100 || regs_in[2] !== 8'h33) begin
                    errors++;
                    $display("FAIL lock_after_write: got we=%b lane2=%h want 0100/33",
                             write_en, regs_in[2]);
                end
            end
            next_cycle();
            case (c)
                0: req_valid = 3'b111;
                2: req_lock  = 3'b000;
                3: req_valid = 3'b101;
                4: req_valid = 3'b000;
                default: ;
            endcase
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_addr  = '{2'd2, 2'd1, 2'd0};
        req_data  = '{8'h33, 8'h22, 8'h11};
        req_valid = 3'b001;
        req_lock  = 3'b001;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL timeout_lock_grant: got %b want 001", req_ready);
        end
        next_cycle();
        req_valid = 3'b100;
        req_lock  = 3'b000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (locked !== 1'b1 || req_ready !== 3'b000) begin
                errors++;
                $display("FAIL timeout_hold cyc %0d: got locked=%b ready=%b want 1/000",
                         c, locked, req_ready);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (locked !== 1'b0 || req_ready !== 3'b100) begin
            errors++;
            $display("FAIL timeout_release: got locked=%b ready=%b want 0/100", locked, req_ready);
        end
`ifdef REG_WRITE_ARB_STATS_EN
        checks++;
        if (lock_to_cnt !== 8'd1) begin
            errors++;
            $display("FAIL stats_lock_to_cnt: got %0d want 1", lock_to_cnt);
        end
`endif
        next_cycle();
        req_valid = 3'b000;
    endtask

    task automatic test_revalidate();
        do_reset();
        req_addr  = '{2'd2, 2'd1, 2'd0};
        req_data  = '{8'h33, 8'h22, 8'h11};
        req_valid = 3'b001;
        req_lock  = 3'b001;
        next_cycle();
        req_valid = 3'b100;
        repeat (7) next_cycle();
        req_valid = 3'b101;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL revalidate_grant: got %b want 001", req_ready);
        end
        next_cycle();
        req_lock = 3'b000;
        @(negedge clk);
        checks++;
        if (locked !== 1'b1 || req_ready !== 3'b001) begin
            errors++;
            $display("FAIL revalidate_stay: got locked=%b ready=%b want 1/001", locked, req_ready);
        end
        next_cycle();
        req_valid = 3'b100;
        @(negedge clk);
        checks++;
        if (locked !== 1'b0 || req_ready !== 3'b100) begin
            errors++;
            $display("FAIL revalidate_release: got locked=%b ready=%b want 0/100",
                     locked, req_ready);
        end
        next_cycle();
        req_valid = 3'b000;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        req_addr  = '{2'd3, 2'd1, 2'd0};
        req_data  = '{8'hA5, 8'h22, 8'h11};
        req_valid = 3'b100;
        req_lock  = 3'b000;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL midrst_accept: got %b want 100", req_ready);
        end
        next_cycle();
        rst       = 1'b1;
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (write_en !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_drop: got we=%b want 0000", write_en);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (write_en !== 4'b0000 || regs_in !== 32'h0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got we=%b regs=%h locked=%b want 0000/0/0",
                     write_en, regs_in, locked);
        end
    endtask

`ifdef REG_WRITE_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req_addr  = '{2'd2, 2'd1, 2'd0};
        req_data  = '{8'h33, 8'h22, 8'h5A};
        req_valid = 3'b001;
        req_lock  = 3'b000;
        repeat (70000) @(posedge clk);
        #1;
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (grant_cnt[0] !== 16'hFFFF || grant_cnt[1] !== 16'h0 || grant_cnt[2] !== 16'h0) begin
            errors++;
            $display("FAIL stats_saturate: got %h/%h/%h want ffff/0/0",
                     grant_cnt[0], grant_cnt[1], grant_cnt[2]);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant_cnt !== 48'h0 || lock_to_cnt !== 8'h0) begin
            errors++;
            $display("FAIL stats_clear: got grant=%h lock_to=%h want 0/0", grant_cnt, lock_to_cnt);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_timeout();
        test_revalidate();
        test_reset_mid_write();
`ifdef REG_WRITE_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
